// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry
// and the baud generator divider constants used by TX, RX and baud logic.
package uart_pkg;

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP      = 3'd3;
   localparam logic [2:0] WAIT_IDLE = 3'd4;

   localparam int unsigned DEF_DATA_BITS  = 8;
   localparam int unsigned DEF_OVERSAMPLE = 16;

   // Baud generator: one sample tick every BAUD_DIV system clocks
   localparam int unsigned CLK_FREQ_HZ = 50_000_000;
   localparam int unsigned BAUD_RATE   = 115_200;
   localparam int unsigned BAUD_DIV    = CLK_FREQ_HZ / (BAUD_RATE * DEF_OVERSAMPLE);

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous level input; resets to 1 so an
// idle-high serial line looks idle straight out of reset.
module uart_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled 8N1-style UART receiver clocked by clk, advanced by sample_tick.
// UART_RX_MAJORITY_EN: 2-of-3 majority vote around each bit centre.
module uart_rx_oversampled
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sample_tick,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 framing_error,
   output logic                 busy
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] CNT_LAST = TW'(OVERSAMPLE - 1);

`ifdef UART_RX_MAJORITY_EN
   // Decision one tick after centre; START reload keeps bit centres aligned
   localparam logic [TW-1:0] START_DEC    = TW'(OVERSAMPLE / 2);
   localparam logic [TW-1:0] BIT_DEC      = '0;
   localparam logic [TW-1:0] START_RELOAD = TW'(1);
   localparam logic [TW-1:0] START_W0     = TW'(OVERSAMPLE / 2 - 2);
   localparam logic [TW-1:0] START_W1     = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] BIT_W0       = TW'(OVERSAMPLE - 2);
   localparam logic [TW-1:0] BIT_W1       = CNT_LAST;
`else
   localparam logic [TW-1:0] START_DEC    = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] BIT_DEC      = CNT_LAST;
   localparam logic [TW-1:0] START_RELOAD = '0;
`endif

   logic                 rx_s;
   logic                 bit_c;
   logic [TW-1:0]        tick_inc_c;
   logic [2:0]           state_q, state_d;
   logic [TW-1:0]        tick_q, tick_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 busy_q, busy_d;

   uart_sync2 u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (rx),
      .q_o   (rx_s)
   );

`ifdef UART_RX_MAJORITY_EN
   logic [1:0]    win_q, win_d;
   logic [TW-1:0] w0_c, w1_c;
   assign w0_c  = (state_q == START) ? START_W0 : BIT_W0;
   assign w1_c  = (state_q == START) ? START_W1 : BIT_W1;
   assign bit_c = maj3(win_q[0], win_q[1], rx_s);
`else
   assign bit_c = rx_s;
`endif

   assign tick_inc_c = (tick_q == CNT_LAST) ? '0 : tick_q + TW'(1);

   // Next-state and output logic; strobes self-clear every clk
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
`ifdef UART_RX_MAJORITY_EN
      win_d   = win_q;
`endif
      if (sample_tick) begin
         tick_d = tick_inc_c;
`ifdef UART_RX_MAJORITY_EN
         if (tick_q == w0_c) win_d[0] = rx_s;
         if (tick_q == w1_c) win_d[1] = rx_s;
`endif
         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  state_d = START;
                  tick_d  = '0;
               end
            end
            START: begin
               if (tick_q == START_DEC) begin
                  if (!bit_c) begin
                     state_d = DATA;
                     tick_d  = START_RELOAD;
                     bit_d   = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            DATA: begin
               if (tick_q == BIT_DEC) begin
                  shift_d = {bit_c, shift_q[DATA_BITS-1:1]};
                  bit_d   = bit_q + BW'(1);
                  if (bit_q == BW'(DATA_BITS - 1)) state_d = STOP;
               end
            end
            STOP: begin
               if (tick_q == BIT_DEC) begin
                  data_d = shift_q;
                  if (bit_c) begin
                     valid_d = 1'b1;
                     state_d = IDLE;
                  end else begin
                     ferr_d  = 1'b1;
                     state_d = WAIT_IDLE;
                  end
               end
            end
            WAIT_IDLE: begin
               if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         busy_q  <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         win_q   <= 2'b11;
`endif
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         busy_q  <= busy_d;
`ifdef UART_RX_MAJORITY_EN
         win_q   <= win_d;
`endif
      end
   end

   assign data_out      = data_q;
   assign data_valid    = valid_q;
   assign framing_error = ferr_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: tick-indexed line plans, a frame-level
// receiver model producing per-tick expectations, and a per-clk compare.
module tb_uart_rx_oversampled;

   localparam int MAXT = 1024;
`ifdef UART_RX_MAJORITY_EN
   localparam int D = 1;
`else
   localparam int D = 0;
`endif

   logic       clk = 1'b0;
   logic       reset;
   logic       sample_tick;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       framing_error;
   logic       busy;

   uart_rx_oversampled #(
      .DATA_BITS  (8),
      .OVERSAMPLE (16)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .sample_tick   (sample_tick),
      .rx            (rx),
      .data_out      (data_out),
      .data_valid    (data_valid),
      .framing_error (framing_error),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   // Line plan: plan[k] is the line level seen by sample tick k
   logic       plan    [MAXT];
   int         n_plan;
   int         ev_kind [MAXT];   // 0 none, 1 valid, 2 framing error after tick k
   logic [7:0] ev_data [MAXT];
   logic       bsy     [MAXT];   // busy after tick k

   logic       exp_valid, exp_ferr, exp_busy;
   logic [7:0] exp_data;
   logic       chk_en = 1'b0;
   int         n_chk = 0, n_err = 0;
   int         n_valid = 0, n_ferr = 0;
   int         v0, f0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("data_valid", 32'(data_valid), 32'(exp_valid));
         chk("framing_error", 32'(framing_error), 32'(exp_ferr));
         chk("busy", 32'(busy), 32'(exp_busy));
         chk("data_out", 32'(data_out), 32'(exp_data));
         if (data_valid === 1'b1) n_valid++;
         if (framing_error === 1'b1) n_ferr++;
      end
   end

   task automatic add_const(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         plan[n_plan] = v;
         n_plan++;
      end
   endtask

   task automatic add_frame(input logic [7:0] b, input logic stop);
      add_const(1'b0, 16);
      for (int i = 0; i < 8; i++) add_const(b[i], 16);
      add_const(stop, 16);
   endtask

   function automatic logic samp(input int t);
`ifdef UART_RX_MAJORITY_EN
      return (plan[t-1] & plan[t]) | (plan[t-1] & plan[t+1]) | (plan[t] & plan[t+1]);
`else
      return plan[t];
`endif
   endfunction

   task automatic mark_busy(input int a, input int b);
      for (int i = a; i <= b; i++) bsy[i] = 1'b1;
   endtask

   // Frame-level model: bit centres sit 8 + 16*n ticks after the first low tick
   task automatic model_run();
      int k, t0, dec, end_t, j;
      logic [7:0] w;
      for (int i = 0; i < n_plan; i++) begin
         ev_kind[i] = 0;
         ev_data[i] = 8'h00;
         bsy[i]     = 1'b0;
      end
      k = 0;
      while (k < n_plan) begin
         if (plan[k]) begin
            k++;
         end else begin
            t0    = k;
            dec   = t0 + 8 + D;
            end_t = t0 + 152 + D;
            if (dec + 1 >= n_plan) begin
               mark_busy(t0, n_plan - 1);
               k = n_plan;
            end else if (samp(t0 + 8)) begin
               mark_busy(t0, dec - 1);
               k = dec + 1;
            end else if (end_t + 1 >= n_plan) begin
               mark_busy(t0, n_plan - 1);
               k = n_plan;
            end else begin
               w = 8'h00;
               for (int b = 0; b < 8; b++) w[b] = samp(t0 + 24 + 16 * b);
               ev_data[end_t] = w;
               if (samp(t0 + 152)) begin
                  ev_kind[end_t] = 1;
                  mark_busy(t0, end_t - 1);
                  k = end_t + 1;
               end else begin
                  ev_kind[end_t] = 2;
                  j = end_t + 1;
                  while (j < n_plan && !plan[j]) j++;
                  mark_busy(t0, j - 1);
                  k = j + 1;
               end
            end
         end
      end
   endtask

   // Expectations for the clk right after tick k-1 has been consumed
   task automatic set_exp_after(input int k);
      exp_valid = 1'b0;
      exp_ferr  = 1'b0;
      if (k > 0) begin
         exp_busy = bsy[k-1];
         if (ev_kind[k-1] != 0) exp_data = ev_data[k-1];
         exp_valid = (ev_kind[k-1] == 1);
         exp_ferr  = (ev_kind[k-1] == 2);
      end
   endtask

   task automatic run_plan();
      model_run();
      for (int k = 0; k < n_plan; k++) begin
         for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
               rx = plan[k];
               set_exp_after(k);
            end else begin
               exp_valid = 1'b0;
               exp_ferr  = 1'b0;
            end
            sample_tick = (c == 3);
         end
      end
      @(posedge clk);
      #1;
      sample_tick = 1'b0;
      set_exp_after(n_plan);
      @(posedge clk);
      #1;
      exp_valid = 1'b0;
      exp_ferr  = 1'b0;
      n_plan = 0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      reset       = 1'b1;
      rx          = 1'b1;
      sample_tick = 1'b0;
      exp_valid   = 1'b0;
      exp_ferr    = 1'b0;
      exp_busy    = 1'b0;
      exp_data    = 8'h00;
      repeat (4) @(posedge clk);
      #1;
      chk("rst_data_out", 32'(data_out), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      reset = 1'b0;
   endtask

   initial begin
      reset       = 1'b1;
      rx          = 1'b1;
      sample_tick = 1'b0;
      exp_valid   = 1'b0;
      exp_ferr    = 1'b0;
      exp_busy    = 1'b0;
      exp_data    = 8'h00;
      n_plan      = 0;
      repeat (2) @(posedge clk);
      #1;
      chk_en = 1'b1;
      do_reset();

      // 1: clean frame
      v0 = n_valid; f0 = n_ferr;
      add_const(1'b1, 5); add_frame(8'hA5, 1'b1); add_const(1'b1, 20);
      run_plan();
      chk("t1_data", 32'(data_out), 32'hA5);
      chk("t1_nvalid", 32'(n_valid - v0), 32'd1);
      chk("t1_nferr", 32'(n_ferr - f0), 32'd0);

      // 2: false start, then a real frame
      v0 = n_valid; f0 = n_ferr;
      add_const(1'b1, 3); add_const(1'b0, 3); add_const(1'b1, 20);
      add_frame(8'h3C, 1'b1); add_const(1'b1, 20);
      run_plan();
      chk("t2_data", 32'(data_out), 32'h3C);
      chk("t2_nvalid", 32'(n_valid - v0), 32'd1);

      // 3: framing error with held-low line, then recovery
      v0 = n_valid; f0 = n_ferr;
      add_const(1'b1, 3); add_frame(8'h3C, 1'b0); add_const(1'b0, 40);
      add_const(1'b1, 20); add_frame(8'h81, 1'b1); add_const(1'b1, 20);
      run_plan();
      chk("t3_data", 32'(data_out), 32'h81);
      chk("t3_nvalid", 32'(n_valid - v0), 32'd1);
      chk("t3_nferr", 32'(n_ferr - f0), 32'd1);

      // 4: reset after four data bits of 0xFF, then 0x00
      v0 = n_valid; f0 = n_ferr;
      add_const(1'b1, 3); add_const(1'b0, 16); add_const(1'b1, 72);
      run_plan();
      chk("t4_busy_mid", 32'(busy), 32'h1);
      do_reset();
      add_const(1'b1, 5); add_frame(8'h00, 1'b1); add_const(1'b1, 20);
      run_plan();
      chk("t4_data", 32'(data_out), 32'h00);
      chk("t4_nvalid", 32'(n_valid - v0), 32'd1);
      chk("t4_nferr", 32'(n_ferr - f0), 32'd0);

      // 5: back-to-back frames with no idle gap
      v0 = n_valid; f0 = n_ferr;
      add_const(1'b1, 3); add_frame(8'h55, 1'b1); add_frame(8'hAA, 1'b1); add_const(1'b1, 20);
      run_plan();
      chk("t5_data", 32'(data_out), 32'hAA);
      chk("t5_nvalid", 32'(n_valid - v0), 32'd2);
      chk("t5_nferr", 32'(n_ferr - f0), 32'd0);

      // 6: one-tick high glitch at the centre of data bit 2 of 0x00
      add_const(1'b1, 3); add_frame(8'h00, 1'b1);
      plan[3 + 16 * 3 + 8] = 1'b1;
      add_const(1'b1, 20);
      run_plan();
`ifdef UART_RX_MAJORITY_EN
      chk("t6_data", 32'(data_out), 32'h00);
`else
      chk("t6_data", 32'(data_out), 32'h04);
`endif

      chk_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
